// File: rtl/hi_lo_muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier replaces the shift-add loop.
module hi_lo_muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            read_req,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIXUP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   mpl_q, mpl_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              isdiv_q, isdiv_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              done_q, done_d;

   logic              sgn;
   logic              is_mul_op;
   logic              is_div_op;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN:0]     add_s;
   logic [XLEN:0]     shl_s;
   logic [XLEN:0]     diff_s;
   logic [2*XLEN-1:0] prod_f;
   logic [XLEN-1:0]   rem_f;
   logic [XLEN-1:0]   quo_f;

   assign sgn       = ~op[0];
   assign is_mul_op = (op[2:1] == 2'b00);
   assign is_div_op = (op[2:1] == 2'b01);
   assign mag_a     = (sgn && operand_a[XLEN-1]) ? -operand_a : operand_a;
   assign mag_b     = (sgn && operand_b[XLEN-1]) ? -operand_b : operand_b;

   // acc holds {product_hi, product_lo} for MUL and {remainder, quotient} for DIV
   assign add_s  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (mpl_q[0] ? {1'b0, opb_q} : '0);
   assign shl_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign diff_s = shl_s - {1'b0, opb_q};

   assign prod_f = qneg_q ? -acc_q : acc_q;
   assign rem_f  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   assign quo_f  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      mpl_d   = mpl_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      isdiv_d = isdiv_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               unique case (1'b1)
                  is_mul_op: begin
                     isdiv_d = 1'b0;
                     qneg_d  = sgn & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                     rneg_d  = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                     acc_d   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
                     state_d = S_FIXUP;
`else
                     acc_d   = '0;
                     opb_d   = mag_a;
                     mpl_d   = mag_b;
                     cnt_d   = '1;
                     state_d = S_MUL;
`endif
                  end
                  is_div_op: begin
                     isdiv_d = 1'b1;
                     if (operand_b == '0) begin
                        acc_d   = {operand_a, {XLEN{1'b1}}};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIXUP;
                     end else begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        opb_d   = mag_b;
                        qneg_d  = sgn & (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                        rneg_d  = sgn & operand_a[XLEN-1];
                        cnt_d   = '1;
                        state_d = S_DIV;
                     end
                  end
                  (op == 3'b100): hi_d = operand_a;
                  (op == 3'b101): lo_d = operand_a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_d = {add_s, acc_q[XLEN-1:1]};
            mpl_d = mpl_q >> 1;
            if (cnt_q == '0) state_d = S_FIXUP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_DIV: begin
            if (!diff_s[XLEN])
               acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
               acc_d = {shl_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            if (cnt_q == '0) state_d = S_FIXUP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FIXUP: begin
            if (isdiv_q) begin
               hi_d = rem_f;
               lo_d = quo_f;
            end else begin
               hi_d = prod_f[2*XLEN-1:XLEN];
               lo_d = prod_f[XLEN-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         mpl_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         isdiv_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         mpl_q   <= mpl_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         isdiv_q <= isdiv_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign stall = busy & (start | read_req);
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv_sequencer.sv
// Self-checking bench for hi_lo_muldiv_sequencer: directed cases plus
// random mul/div checked against an arithmetic reference model.
module tb_hi_lo_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        read_req = 1'b0;
   logic [2:0]  op = 3'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, stall, done;
   logic [31:0] hi, lo;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mh = '0;
   logic [31:0] ml = '0;

   always #5 clk = ~clk;

   hi_lo_muldiv_sequencer #(.XLEN(32)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op(op),
      .operand_a(a),
      .operand_b(b),
      .read_req(read_req),
      .busy(busy),
      .stall(stall),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // {hi, lo} from the architectural definition of each op
   function automatic logic [63:0] model(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = $signed(x);
      sy = $signed(y);
      p  = '0;
      case (o)
         3'd0: begin
            q = sx * sy;
            p = q;
         end
         3'd1: p = {32'b0, x} * {32'b0, y};
         3'd2: begin
            if (y == 0) p = {x, 32'hFFFFFFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (y == 0) p = {x, 32'hFFFFFFFF};
            else p = {x % y, x / y};
         end
      endcase
      return p;
   endfunction

   task automatic wait_commit(input string tag, input int lat,
                              input logic [31:0] eh, input logic [31:0] el);
      for (int i = 1; i < lat; i++) begin
         @(posedge clk); #1;
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_nodone"}, done, 0);
         chk({tag, "_hold"}, {hi, lo}, {mh, ml});
      end
      @(posedge clk); #1;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_hi"}, hi, eh);
      chk({tag, "_lo"}, lo, el);
      mh = eh;
      ml = el;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
      int lat;
      lat = (o[1] == 1'b0) ? MUL_LAT : ((y == 0) ? 1 : 33);
      @(negedge clk);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_accept"}, busy, 1);
      wait_commit(tag, lat, eh, el);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      logic [63:0] m;
      logic        seen;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_stall", stall, 0);
      @(negedge clk);
      reset = 1'b0;

      run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7,
             32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("divu_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000);

      // DIVU in flight, then read_req plus a held MULT that must wait
      @(negedge clk);
      start = 1'b1;
      op = 3'd3;
      a = 32'd1000;
      b = 32'd3;
      @(posedge clk); #1;
      op = 3'd0;
      a = 32'd3;
      b = 32'hFFFFFFFB;
      read_req = 1'b1;
      chk("st_stall0", stall, 1);
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk); #1;
         chk("st_stall", stall, 1);
         chk("st_busy", busy, 1);
         chk("st_hold", {hi, lo}, {mh, ml});
      end
      @(posedge clk); #1;
      chk("st_done", done, 1);
      chk("st_idle", busy, 0);
      chk("st_nostall", stall, 0);
      chk("st_hi", hi, 32'd1);
      chk("st_lo", lo, 32'd333);
      mh = 32'd1;
      ml = 32'd333;
      read_req = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("re_accept", busy, 1);
      wait_commit("re_mult", MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1);

      // MTLO / MTHI in idle, then an ignored 11x op
      @(negedge clk);
      start = 1'b1;
      op = 3'd5;
      a = 32'h1234;
      @(posedge clk); #1;
      chk("mtlo_lo", lo, 32'h1234);
      chk("mtlo_hi", hi, mh);
      chk("mtlo_busy", busy, 0);
      chk("mtlo_done", done, 0);
      op = 3'd4;
      a = 32'hABCD;
      @(posedge clk); #1;
      chk("mthi_hi", hi, 32'hABCD);
      chk("mthi_lo", lo, 32'h1234);
      chk("mthi_busy", busy, 0);
      chk("mthi_done", done, 0);
      mh = 32'hABCD;
      ml = 32'h1234;
      op = 3'd6;
      a = 32'h5555;
      @(posedge clk); #1;
      op = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
      chk("op11x_busy", busy, 0);
      chk("op11x_hilo", {hi, lo}, {mh, ml});

      // reset in the middle of a MULTU
      @(negedge clk);
      start = 1'b1;
      op = 3'd1;
      a = 32'hFFFFFFFF;
      b = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_hi", hi, 0);
      chk("mrst_lo", lo, 0);
      mh = '0;
      ml = '0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("mrst_nodone", seen, 0);

      for (int n = 0; n < 30; n++) begin
         ro = 3'($urandom_range(0, 3));
         rx = $urandom;
         ry = $urandom;
         if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 20);
         if ($urandom_range(0, 3) == 0) rx = $urandom_range(0, 50);
         m = model(ro, rx, ry);
         run_op("rnd", ro, rx, ry, m[63:32], m[31:0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hi_lo_muldiv_sequencer.md
Name: hi_lo_muldiv_sequencer

Overview:
Iterative multiply/divide sequencer that owns the architectural HI/LO registers of the pipelined CPU. The execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here. The block runs a multi-cycle shift-add or restoring-divide sequence and commits results to HI/LO. It also drives a stall request to the hazard unit when a HI/LO consumer, or a second mul/div, arrives while an operation is in flight.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits. Only 32 is required to be verified.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  issue request from execute stage, sampled on posedge clk
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
operand_a  in  XLEN  rs value (dividend / multiplicand / MTHI/MTLO source)
operand_b  in  XLEN  rt value (divisor / multiplier)
read_req  in  1  MFHI/MFLO present in decode/execute
busy  out  1  operation in flight
stall  out  1  combinational stall request: busy && (start || read_req)
done  out  1  one-cycle pulse after a MULT/MULTU/DIV/DIVU commits
hi  out  XLEN  architectural HI register
lo  out  XLEN  architectural LO register

Behaviour:
- Reset, including mid-operation: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0, internal accumulators cleared. Any in-flight operation is abandoned.
- States: IDLE, MUL, DIV, FIXUP. busy=1 exactly in MUL, DIV and FIXUP.
- IDLE, start with op MULT/MULTU:
  - Latch |a| and |b|; signed ops only, otherwise raw operands.
  - Latch result sign = a[31]^b[31] for MULT, 0 for MULTU.
  - Clear 64-bit product; counter=31; go to MUL.
- MUL: each edge performs one shift-add step. At counter==0, go to FIXUP; otherwise decrement the counter. 32 edges total.
- IDLE, start with op DIV/DIVU and operand_b!=0:
  - Latch magnitudes (signed) or raw operands.
  - quotient sign = a[31]^b[31]; remainder sign = a[31] (DIVU: both 0).
  - counter=31; go to DIV.
- DIV: one restoring step per edge (shift remainder, trial subtract, set quotient bit). 32 edges, then FIXUP.
- DIV/DIVU with operand_b==0: no iterations; go straight to FIXUP. Committed values are hi=operand_a, lo=32'hFFFFFFFF. No trap.
- FIXUP:
  - Apply sign correction (two's-complement negate where the sign flag is set).
  - Write hi/lo: MUL gives product[63:32]/product[31:0]; DIV gives remainder/quotient.
  - Go to IDLE. done=1 for the following cycle only.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No special case; this result falls out of the magnitude algorithm.
- Latency from the accepting edge E0:
  - Mul and nonzero-divisor div commit at edge E0+33; done and !busy are visible after E0+33.
  - Divide-by-zero commits at E0+1.
- MTHI/MTLO in IDLE: hi or lo := operand_a at the same edge. No busy, no done.
- hi/lo hold their previous values throughout MUL/DIV and change only in FIXUP, MTHI/MTLO, or reset.
- start while busy: ignored; no state change; stall=1. The pipeline must hold and re-present start.
- read_req while busy: stall=1. read_req when !busy: stall=0, and hi/lo are valid.
- start in the cycle done=1: accepted normally (busy=0 in that cycle).
- start with op 11x: ignored in all states.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU form the 64-bit product with a single-cycle multiplier at E0 and go straight to FIXUP. Commit is at E0+1 and done follows. DIV/DIVU are unchanged; the MUL state is unused.
- Undefined: the 32-iteration shift-add path described in Behaviour.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy for 33 cycles; done pulses once after E0+33 (after E0+1 with MULDIV_FAST_MUL_EN).
- MULT 0xFFFFFFFD*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, done after E0+1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 1000/3, then read_req=1 and a second start (MULT) while busy:
  - stall=1 every busy cycle; second start ignored.
  - hi/lo keep their old values until commit: lo=333, hi=1.
  - Re-presented MULT is accepted in the done cycle.
- Idle MTLO 0x1234 then MTHI 0xABCD -> lo=0x1234 and hi=0xABCD one edge after each; busy=0, done=0 throughout.
- MULTU in progress, reset asserted at iteration 10 -> next cycle busy=0, done=0, hi=lo=0; no later done pulse.
